cpu_sequencer: RTL

Multi-cycle control unit for the 16-bit CPU. It fetches each instruction from the shared 256x16 memory, latches it into the instruction register, and steps the register file, ALU/flags and PC through one instruction at a time. It also supports run/single-step control and a sticky halt. It sits between the memory port and the datapath (register file, execute unit with N/Z flags) and owns the program counter.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cpu_decode.sv | 39 +++
 rtl/cpu_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state and datapath-control encodings for the 16-bit CPU
package cpu_pkg;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_JN   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_PASS = 2'd2;

    localparam logic [1:0] WSEL_IMM = 2'd0;
    localparam logic [1:0] WSEL_ALU = 2'd1;
    localparam logic [1:0] WSEL_MEM = 2'd2;

endpackage

// File: rtl/cpu_decode.sv
// rtl/cpu_decode.sv - opcode classifier feeding the sequencer control decisions
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_mem,
    output logic       is_jump,
    output logic       is_halt,
    output logic       is_illegal,
    output logic       writes_rf
);

    always_comb begin
        is_alu     = 1'b0;
        is_mem     = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        writes_rf  = 1'b0;
        case (opcode)
            OP_LDI:                 writes_rf = 1'b1;
            OP_ADD, OP_SUB: begin
                is_alu    = 1'b1;
                writes_rf = 1'b1;
            end
            OP_CMP:                 is_alu = 1'b1;
            OP_LD: begin
                is_mem    = 1'b1;
                writes_rf = 1'b1;
            end
            OP_ST:                  is_mem = 1'b1;
            OP_JMP, OP_JZ, OP_JN:   is_jump = 1'b1;
            OP_HALT:                is_halt = 1'b1;
            default:                is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute control unit owning the PC and IR
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir,
    output logic [7:0]  pc,
    input  logic        flag_n,
    input  logic        flag_z,
    output logic [3:0]  rf_ra1,
    output logic [3:0]  rf_ra2,
    output logic [3:0]  rf_wa,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic [1:0]  alu_op,
    output logic        flags_we,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t      state_q, state_d;
    logic [15:0] ir_q;
    logic [7:0]  pc_q;
    logic        illegal_q;
    logic        is_alu, is_mem, is_jump, is_halt, is_illegal, writes_rf;
    logic        take_jump;
    state_t      boundary_next;

    cpu_decode u_decode (
        .opcode     (ir_q[15:12]),
        .is_alu     (is_alu),
        .is_mem     (is_mem),
        .is_jump    (is_jump),
        .is_halt    (is_halt),
        .is_illegal (is_illegal),
        .writes_rf  (writes_rf)
    );

    // Conditional jumps use the flags as they stand during EXEC of the jump itself.
    assign take_jump = is_jump && ((ir_q[15:12] == OP_JMP)
                                || (ir_q[15:12] == OP_JZ && flag_z)
                                || (ir_q[15:12] == OP_JN && flag_n));

    assign boundary_next = run ? ST_FETCH : ST_IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ir_q      <= 16'h0000;
            pc_q      <= RESET_PC;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && mem_ack) begin
                ir_q <= mem_rdata;
            end
            if (state_q == ST_DECODE) begin
                pc_q <= pc_q + 8'd1;
                if (is_illegal) begin
                    illegal_q <= 1'b1;
                end
            end
            if (state_q == ST_EXEC && take_jump) begin
                pc_q <= ir_q[7:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        rf_we    = 1'b0;
        rf_wsel  = WSEL_IMM;
        alu_op   = ALU_ADD;
        flags_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run || step) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = (is_illegal || is_halt) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                rf_we = writes_rf && !is_mem;
                if (is_alu) begin
                    rf_wsel  = WSEL_ALU;
                    flags_we = 1'b1;
                    alu_op   = (ir_q[15:12] == OP_ADD) ? ALU_ADD : ALU_SUB;
                end
                state_d = is_mem ? ST_MEM : boundary_next;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_addr = ir_q[7:0];
                mem_we   = (ir_q[15:12] == OP_ST);
                if (mem_ack) begin
                    if (ir_q[15:12] == OP_LD) begin
                        rf_we   = 1'b1;
                        rf_wsel = WSEL_MEM;
                    end
                    state_d = boundary_next;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ir      = ir_q;
    assign pc      = pc_q;
    assign rf_ra1  = ir_q[11:8];
    assign rf_ra2  = ir_q[7:4];
    assign rf_wa   = ir_q[11:8];
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule
